cnt12b_down: RTL and testbench
==============================

Name: cnt12b_down

Overview:
- Modulo-12 down counter. It is the reverse-direction companion of the team's 4..15 up counter.
- Counts Q from HIGH (15) down to LOW (4), raises TC at LOW, then reloads HIGH on the next enabled edge.
- Supports synchronous parallel load and HC161-style CEP/CET enables, so stages can be cascaded through TC/CET.
- Used in countdown and timer paths in the Counter project.

Parameters:
- W, 4, counter width in bits.
- HIGH, 15, reload/top value. Range 0..2^W-1, and HIGH > LOW.
- LOW, 4, terminal/bottom value. Modulus is HIGH-LOW+1 = 12 with the defaults.

Ports:
- Clk  input  1  rising-edge clock.
- MR  input  1  asynchronous reset, active-high.
- CEP  input  1  count enable, parallel.
- CET  input  1  count enable, trickle. Also gates TC.
- PE  input  1  synchronous parallel load, active-high. Has priority over counting.
- D  input  W  parallel load data.
- Q  output  W  registered count.
- TC  output  1  terminal count, combinational: TC = CET & (Q == LOW).

Behaviour:
- Reset
  - MR=1 forces Q=HIGH (4'd15) immediately, independent of Clk.
  - While MR=1, TC = CET & (HIGH==LOW), which is 0 for legal parameters.
  - On MR deassertion, Q holds HIGH until the first qualifying edge.
- Priority at each rising Clk edge with MR=0, highest first:
  - PE=1: Q <= D. Load ignores CEP/CET.
  - CEP=1 and CET=1 and Q<=LOW: Q <= HIGH (wrap/reload).
  - CEP=1 and CET=1 and LOW<Q<=HIGH: Q <= Q-1.
  - CEP=1 and CET=1 and Q>HIGH: Q <= Q-1. Decrements back into range with no special case.
  - Otherwise: Q holds.
- Out-of-range load
  - D is loaded unchanged, with no clamping.
  - D<LOW: the next enabled count gives Q=HIGH (same path as Q<=LOW).
  - D>HIGH: counts down normally, reaching HIGH after D-HIGH enabled edges.
  - TC asserts only at Q==LOW exactly, never for Q<LOW.
- TC
  - Zero-latency combinational decode of the registered Q and live CET. No glitch filtering.
  - For cascading, the downstream stage's CET = upstream TC and its CEP = 1.
  - The downstream stage therefore decrements exactly on the edge where the upstream stage wraps LOW->HIGH.
- Sequence with enables held high from reset: 15,14,...,5,4(TC=1),15,...
  - Period is 12 Clk cycles.
  - TC is high for exactly 1 cycle per period.
- Simultaneous events
  - PE=1 and CEP=CET=1 at Q==LOW: the load wins, Q <= D, and no reload occurs.
  - MR asserted mid-count or mid-load overrides everything asynchronously.
- Arithmetic: all W-bit unsigned. The decrement never underflows below 0 in-range, because Q==0 only occurs when LOW==0 or after a load, and is then caught by the Q<=LOW reload.

Test Plan:
- Reset: MR=1 pulsed mid-cycle with Q=7 -> Q=15 at once, without waiting for an edge; TC=0; Q remains 15 after release until an enabled edge.
- Free run: CEP=CET=1, PE=0 for 26 edges after reset -> Q sequence 14,13,...,4,15,14,...; TC=1 only while Q=4 (cycles 11 and 23); period 12.
- Enables: at Q=9 hold CEP=0 for 3 edges -> Q stays 9. Then CEP=1, CET=0 -> Q stays 9. Then force Q=4 via load with CET=0 -> TC=0; raise CET -> TC=1 in the same cycle.
- Load: PE=1, D=6 at Q=12 -> Q=6 next edge. PE=1, D=2 -> Q=2, TC=0; next enabled edge -> Q=15. PE=1 with CEP=CET=1 at Q=4 and D=10 -> Q=10, not 15.
- Cascade: two instances, stage1 CET=stage0 TC, both CEP=1, 144 edges -> stage1 decrements only on edges where stage0 goes 4->15; both are back at (15,15) after 144 edges; stage1 TC&stage0 TC high for exactly 1 cycle.

Source files
------------

// File: rtl/cnt12b_down.sv
// Modulo-(HIGH-LOW+1) down counter with parallel load and HC161-style CEP/CET enables.
// Counts HIGH down to LOW, flags TC at LOW, then reloads HIGH on the next enabled edge.
module cnt12b_down #(
    parameter int unsigned W    = 4,
    parameter int unsigned HIGH = 15,
    parameter int unsigned LOW  = 4
) (
    input  logic         Clk,
    input  logic         MR,
    input  logic         CEP,
    input  logic         CET,
    input  logic         PE,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic         TC
);

    localparam logic [W-1:0] HighVal = W'(HIGH);
    localparam logic [W-1:0] LowVal  = W'(LOW);
    localparam logic [W-1:0] One     = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         count_en;

    assign count_en = CEP & CET;

    always_comb begin
        count_d = count_q;
        if (PE) begin
            count_d = D;
        end else if (count_en) begin
            // Values at or below LOW (only reachable via load) take the reload path too.
            if (count_q <= LowVal) begin
                count_d = HighVal;
            end else begin
                count_d = count_q - One;
            end
        end
    end

    always_ff @(posedge Clk or posedge MR) begin
        if (MR) begin
            count_q <= HighVal;
        end else begin
            count_q <= count_d;
        end
    end

    assign Q  = count_q;
    assign TC = CET & (count_q == LowVal);

endmodule

// File: tb/tb_cnt12b_down.sv
// Self-checking bench for cnt12b_down: directed vector table, reset/enable corners,
// randomized run against an arithmetic reference model, and a two-stage cascade.
module tb_cnt12b_down;

    localparam int W    = 4;
    localparam int HIGH = 15;
    localparam int LOW  = 4;
    localparam int MOD  = HIGH - LOW + 1;

    logic         clk;
    logic         mr, cep, cet, pe;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         tc;

    logic         csc_mr, csc_en;
    logic [W-1:0] q0, q1;
    logic         tc0, tc1;
    logic [W-1:0] zero_d;

    int tests  = 0;
    int failed = 0;
    int m;          // reference model of the single DUT's count

    typedef struct {
        logic       pe;
        logic       cep;
        logic       cet;
        logic [3:0] d;
        int         exp_q;
        logic       exp_tc;
    } vec_t;

    cnt12b_down #(.W(W), .HIGH(HIGH), .LOW(LOW)) dut (
        .Clk(clk), .MR(mr), .CEP(cep), .CET(cet), .PE(pe), .D(d), .Q(q), .TC(tc)
    );

    cnt12b_down #(.W(W), .HIGH(HIGH), .LOW(LOW)) u_s0 (
        .Clk(clk), .MR(csc_mr), .CEP(1'b1), .CET(csc_en), .PE(1'b0), .D(zero_d),
        .Q(q0), .TC(tc0)
    );

    cnt12b_down #(.W(W), .HIGH(HIGH), .LOW(LOW)) u_s1 (
        .Clk(clk), .MR(csc_mr), .CEP(1'b1), .CET(tc0), .PE(1'b0), .D(zero_d),
        .Q(q1), .TC(tc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Next count from the rules: reload at/below LOW, plain decrement above HIGH,
    // modular step inside the LOW..HIGH window.
    function automatic int model_next(input int v);
        if (v <= LOW) return HIGH;
        if (v > HIGH) return v - 1;
        return LOW + ((v - LOW) + MOD - 1) % MOD;
    endfunction

    task automatic tick();
        if (pe) m = int'(d);
        else if (cep && cet) m = model_next(m);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        check({name, ".q"}, int'(q), m);
        check({name, ".tc"}, int'(tc), int'(cet && (m == LOW)));
    endtask

    vec_t vecs[14];
    int   tc_cnt;
    int   exp0, exp1;

    initial begin
        zero_d = '0;
        mr = 1'b1; cep = 1'b0; cet = 1'b1; pe = 1'b0; d = '0;
        csc_mr = 1'b1; csc_en = 1'b0;
        m = HIGH;
        #1;
        check("reset.q", int'(q), 15);
        check("reset.tc", int'(tc), 0);

        @(posedge clk); #1;
        mr = 1'b0;
        tick(); tick();
        check("post_reset_hold.q", int'(q), 15);

        // Directed table, applied one vector per edge starting from Q=15.
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 4'd0,  14, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd6,  6,  1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'd0,  5,  1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'd0,  4,  1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 4'd10, 10, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'd0,  10, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd0,  10, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd2,  2,  1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'd0,  15, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd4,  4,  1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'd0,  4,  1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 4'd0,  15, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 4'd0,  0,  1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 4'd0,  15, 1'b0};
        for (int i = 0; i < 14; i++) begin
            pe = vecs[i].pe; cep = vecs[i].cep; cet = vecs[i].cet; d = vecs[i].d;
            tick();
            check($sformatf("vec%0d.q", i), int'(q), vecs[i].exp_q);
            check($sformatf("vec%0d.tc", i), int'(tc), int'(vecs[i].exp_tc));
        end

        // Asynchronous reset mid-cycle with Q=7.
        pe = 1'b1; d = 4'd7; cep = 1'b0; cet = 1'b1;
        tick();
        check("load7.q", int'(q), 7);
        pe = 1'b0;
        #2 mr = 1'b1;
        #1;
        check("async_reset.q", int'(q), 15);
        check("async_reset.tc", int'(tc), 0);
        #1 mr = 1'b0;
        m = HIGH;
        tick();
        check("reset_release_hold.q", int'(q), 15);

        // Free run, 26 edges.
        cep = 1'b1; cet = 1'b1;
        tc_cnt = 0;
        for (int i = 1; i <= 26; i++) begin
            tick();
            check($sformatf("free%0d.q", i), int'(q), 15 - (i % 12));
            check($sformatf("free%0d.tc", i), int'(tc), int'((i % 12) == 11));
            if (tc) tc_cnt++;
        end
        check("free.tc_count", tc_cnt, 2);

        // Enables at Q=9, then TC follows CET combinationally.
        pe = 1'b1; d = 4'd9; tick(); pe = 1'b0;
        cep = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cep_low_hold.q", int'(q), 9);
        end
        cep = 1'b1; cet = 1'b0;
        tick();
        check("cet_low_hold.q", int'(q), 9);
        pe = 1'b1; d = 4'd4; tick(); pe = 1'b0; cep = 1'b0;
        check("tc_gated.tc", int'(tc), 0);
        cet = 1'b1;
        #1;
        check("tc_same_cycle.tc", int'(tc), 1);

        // Randomized run against the reference model.
        for (int i = 0; i < 400; i++) begin
            pe  = ($urandom_range(0, 7) == 0);
            cep = ($urandom_range(0, 3) != 0);
            cet = ($urandom_range(0, 3) != 0);
            d   = W'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) begin
                #2 mr = 1'b1;
                #1;
                m = HIGH;
                check("rand_async_reset.q", int'(q), m);
                mr = 1'b0;
            end
            tick();
            check_model("rand");
        end

        // Two-stage cascade for 144 edges.
        pe = 1'b0; cep = 1'b0;
        csc_en = 1'b1;
        #1 csc_mr = 1'b0;
        tc_cnt = 0;
        for (int i = 1; i <= 144; i++) begin
            @(posedge clk); #1;
            exp0 = 15 - (i % 12);
            exp1 = 15 - ((i / 12) % 12);
            check($sformatf("csc%0d.q0", i), int'(q0), exp0);
            check($sformatf("csc%0d.q1", i), int'(q1), exp1);
            if (tc0 && tc1) tc_cnt++;
        end
        check("csc.final_q0", int'(q0), 15);
        check("csc.final_q1", int'(q1), 15);
        check("csc.both_tc_cycles", tc_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got 1, expected 0");
        $fatal(1, "timeout");
    end

endmodule
